led_mode_ctrl: RTL and testbench

Mode sequencer and time-base scheduler for the board LED. It owns one shared 1 ms prescaler and one millisecond phase counter, which it configures per mode. A single-cycle key pulse steps it through five display modes: off, on, slow blink, fast blink and burst. It sits between the debounced key logic and the LED pin and replaces free-running toggle counters.

---
 rtl/led_mode_ctrl.sv | 143 ++++++++++++++
 tb/tb_led_mode_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Board LED mode sequencer. One shared 1 ms prescaler and one millisecond phase
// counter serve five display modes, and a debounced key pulse steps between them.
module led_mode_ctrl #(
    parameter logic [15:0] TICK_MAX = 16'd49_999,
    parameter logic [10:0] SLOW_MS  = 11'd500,
    parameter logic [10:0] FAST_MS  = 11'd100,
    parameter logic [2:0]  BURST_N  = 3'd3,
    parameter logic [10:0] PAUSE_MS = 11'd1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag,
    input  logic       hold,
    output logic       led_out,
    output logic [2:0] mode,
    output logic       tick_ms
);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_SLOW  = 3'd2,
        MODE_FAST  = 3'd3,
        MODE_BURST = 3'd4
    } mode_e;

    typedef enum logic {
        PH_BLINK = 1'b0,
        PH_PAUSE = 1'b1
    } phase_e;

    mode_e       mode_q, mode_d, mode_next_s;
    phase_e      phase_q, phase_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [10:0] ms_cnt_q, ms_cnt_d;
    logic [2:0]  pulse_cnt_q, pulse_cnt_d;
    logic        led_q, led_d;
    logic        tick_s;
    logic [10:0] half_s;
    logic [2:0]  pulse_inc_s;

    assign tick_s      = (pre_cnt_q == TICK_MAX) && !hold;
    assign tick_ms     = tick_s;
    assign led_out     = led_q;
    assign mode        = mode_q;
    assign half_s      = (mode_q == MODE_SLOW) ? SLOW_MS : FAST_MS;
    assign pulse_inc_s = pulse_cnt_q + 3'd1;

    // Successor mode in the key-advance ring.
    always_comb begin
        case (mode_q)
            MODE_OFF:   mode_next_s = MODE_ON;
            MODE_ON:    mode_next_s = MODE_SLOW;
            MODE_SLOW:  mode_next_s = MODE_FAST;
            MODE_FAST:  mode_next_s = MODE_BURST;
            MODE_BURST: mode_next_s = MODE_OFF;
            default:    mode_next_s = MODE_OFF;
        endcase
    end

    // Next-state logic; a key press overrides any coincident tick, and hold freezes timing only.
    always_comb begin
        mode_d      = mode_q;
        phase_d     = phase_q;
        pre_cnt_d   = pre_cnt_q;
        ms_cnt_d    = ms_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        led_d       = led_q;
        if (key_flag) begin
            mode_d      = mode_next_s;
            phase_d     = PH_BLINK;
            pre_cnt_d   = 16'd0;
            ms_cnt_d    = 11'd0;
            pulse_cnt_d = 3'd0;
            led_d       = (mode_next_s != MODE_OFF);
        end else if (!hold) begin
            pre_cnt_d = tick_s ? 16'd0 : pre_cnt_q + 16'd1;
            if (tick_s) begin
                case (mode_q)
                    MODE_SLOW, MODE_FAST: begin
                        if (ms_cnt_q == half_s - 11'd1) begin
                            led_d    = ~led_q;
                            ms_cnt_d = 11'd0;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 11'd1;
                        end
                    end
                    MODE_BURST: begin
                        if (phase_q == PH_BLINK) begin
                            if (ms_cnt_q == FAST_MS - 11'd1) begin
                                ms_cnt_d = 11'd0;
                                if (led_q) begin
                                    // Falling edge closes one on-pulse of the burst.
                                    led_d       = 1'b0;
                                    pulse_cnt_d = pulse_inc_s;
                                    phase_d     = (pulse_inc_s == BURST_N) ? PH_PAUSE : PH_BLINK;
                                end else begin
                                    led_d = 1'b1;
                                end
                            end else begin
                                ms_cnt_d = ms_cnt_q + 11'd1;
                            end
                        end else begin
                            if (ms_cnt_q == PAUSE_MS - 11'd1) begin
                                led_d       = 1'b1;
                                pulse_cnt_d = 3'd0;
                                ms_cnt_d    = 11'd0;
                                phase_d     = PH_BLINK;
                            end else begin
                                ms_cnt_d = ms_cnt_q + 11'd1;
                            end
                        end
                    end
                    default: ms_cnt_d = ms_cnt_q;
                endcase
            end else begin
                ms_cnt_d = ms_cnt_q;
            end
        end else begin
            pre_cnt_d = pre_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q      <= MODE_OFF;
            phase_q     <= PH_BLINK;
            pre_cnt_q   <= 16'd0;
            ms_cnt_q    <= 11'd0;
            pulse_cnt_q <= 3'd0;
            led_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            pre_cnt_q   <= pre_cnt_d;
            ms_cnt_q    <= ms_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with a 5-cycle tick, checked by immediate assertions.
module tb_led_mode_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_flag;
    logic       hold;
    logic       led_out;
    logic [2:0] mode;
    logic       tick_ms;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    led_mode_ctrl #(
        .TICK_MAX(16'd4),
        .SLOW_MS (11'd4),
        .FAST_MS (11'd2),
        .BURST_N (3'd2),
        .PAUSE_MS(11'd6)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_flag (key_flag),
        .hold     (hold),
        .led_out  (led_out),
        .mode     (mode),
        .tick_ms  (tick_ms)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic clk(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One-cycle key pulse; returns just after the edge that registered it.
    task automatic press();
        key_flag = 1'b1;
        clk(1);
        key_flag = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_flag  = 1'b0;
        hold      = 1'b0;
        clk(2);
        check("rst_led", {31'd0, led_out}, 32'd0);
        check("rst_mode", {29'd0, mode}, 32'd0);
        check("rst_tick", {31'd0, tick_ms}, 32'd0);

        // Idle after release: tick_ms high after edges 4, 9, 14, ...
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            clk(1);
            check("idle_tick", {31'd0, tick_ms}, {31'd0, (k % 5) == 4});
            check("idle_led", {31'd0, led_out}, 32'd0);
            check("idle_mode", {29'd0, mode}, 32'd0);
        end

        press();
        check("on_mode", {29'd0, mode}, 32'd1);
        check("on_led", {31'd0, led_out}, 32'd1);
        for (int k = 1; k <= 200; k++) begin
            clk(1);
            check("on_hold_led", {31'd0, led_out}, 32'd1);
            check("on_hold_mode", {29'd0, mode}, 32'd1);
        end

        // SLOW: 20 cycles lit, 20 dark.
        press();
        check("slow_mode", {29'd0, mode}, 32'd2);
        check("slow_entry_led", {31'd0, led_out}, 32'd1);
        for (int k = 1; k <= 80; k++) begin
            clk(1);
            check("slow_led", {31'd0, led_out}, {31'd0, ((k / 20) % 2) == 0});
        end

        // FAST: 10 lit, 10 dark; entry lands right after a SLOW toggle.
        press();
        check("fast_mode", {29'd0, mode}, 32'd3);
        check("fast_entry_led", {31'd0, led_out}, 32'd1);
        for (int k = 1; k <= 60; k++) begin
            clk(1);
            check("fast_led", {31'd0, led_out}, {31'd0, ((k / 10) % 2) == 0});
        end

        // BURST: 1x10, 0x10, 1x10, 0x30, period 60.
        press();
        check("burst_mode", {29'd0, mode}, 32'd4);
        check("burst_entry_led", {31'd0, led_out}, 32'd1);
        for (int k = 1; k <= 120; k++) begin
            clk(1);
            check("burst_led", {31'd0, led_out},
                  {31'd0, ((k % 60) < 10) || (((k % 60) >= 20) && ((k % 60) < 30))});
            if ((k % 60) == 0) begin
                check("burst_pulse_restart", {29'd0, dut.pulse_cnt_q}, 32'd0);
            end else if ((k % 60) == 59) begin
                check("burst_pulse_pause", {29'd0, dut.pulse_cnt_q}, 32'd2);
            end else if ((k % 60) == 15) begin
                check("burst_pulse_mid", {29'd0, dut.pulse_cnt_q}, 32'd1);
            end
        end

        press();
        check("wrap_mode", {29'd0, mode}, 32'd0);
        check("wrap_led", {31'd0, led_out}, 32'd0);

        // Key coincident with a tick in SLOW: mode change wins, timers restart.
        press();
        press();
        check("coin_slow_mode", {29'd0, mode}, 32'd2);
        clk(4);
        check("coin_tick_high", {31'd0, tick_ms}, 32'd1);
        press();
        check("coin_mode", {29'd0, mode}, 32'd3);
        check("coin_led", {31'd0, led_out}, 32'd1);
        check("coin_ms_cnt", {21'd0, dut.ms_cnt_q}, 32'd0);
        check("coin_pre_cnt", {16'd0, dut.pre_cnt_q}, 32'd0);
        clk(9);
        check("coin_fast_before_fall", {31'd0, led_out}, 32'd1);
        clk(1);
        check("coin_fast_fall", {31'd0, led_out}, 32'd0);

        // Hold for 17 cycles mid-half-period in SLOW delays the toggle by 17.
        press();
        press();
        press();
        press();
        check("hold_slow_mode", {29'd0, mode}, 32'd2);
        check("hold_slow_led", {31'd0, led_out}, 32'd1);
        clk(7);
        hold = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            clk(1);
            check("hold_tick_low", {31'd0, tick_ms}, 32'd0);
        end
        hold = 1'b0;
        clk(12);
        check("hold_before_toggle", {31'd0, led_out}, 32'd1);
        clk(1);
        check("hold_toggle", {31'd0, led_out}, 32'd0);

        // Asynchronous reset mid-BURST.
        press();
        press();
        check("rst_burst_mode", {29'd0, mode}, 32'd4);
        clk(15);
        check("rst_burst_pulse_pre", {29'd0, dut.pulse_cnt_q}, 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_led", {31'd0, led_out}, 32'd0);
        check("async_rst_mode", {29'd0, mode}, 32'd0);
        check("async_rst_pulse", {29'd0, dut.pulse_cnt_q}, 32'd0);
        check("async_rst_ms", {21'd0, dut.ms_cnt_q}, 32'd0);
        clk(2);
        sys_rst_n = 1'b1;
        press();
        check("post_rst_mode", {29'd0, mode}, 32'd1);
        check("post_rst_led", {31'd0, led_out}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
